// File: rtl/qr_proj_ctrl.sv
// qr_proj_ctrl: sequences the modified Gram-Schmidt QR loop around the column
// normalizer, the inner-product unit and the projection datapath.
module qr_proj_ctrl #(
  parameter int N_COL    = 4,
  parameter int RIJ_W    = 40,
  parameter int PROJ_LAT = 1,
  localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_norm_start,
  input  logic             i_norm_done,
  output logic             o_ip_start,
  input  logic             i_ip_valid,
  input  logic [RIJ_W-1:0] i_ip_rij,
  output logic [CW-1:0]    o_k,
  output logic [CW-1:0]    o_j,
  output logic [RIJ_W-1:0] o_rij,
  output logic             o_proj_fire,
  output logic             o_wb_en,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_NORM_REQ  = 4'd1;
  localparam logic [3:0] S_NORM_WAIT = 4'd2;
  localparam logic [3:0] S_IP_REQ    = 4'd3;
  localparam logic [3:0] S_IP_WAIT   = 4'd4;
  localparam logic [3:0] S_PROJ      = 4'd5;
  localparam logic [3:0] S_PROJ_WAIT = 4'd6;
  localparam logic [3:0] S_WB        = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  // Extra projection cycles beyond PROJ are counted down from PROJ_LAT-2.
  localparam int PW = (PROJ_LAT > 2) ? $clog2(PROJ_LAT - 1) : 1;
  localparam logic [PW-1:0] PROJ_CNT_INIT = PW'((PROJ_LAT > 1) ? (PROJ_LAT - 2) : 0);
  localparam logic [CW-1:0] LAST_COL = CW'(N_COL - 1);

  logic [3:0]       state_q, state_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW-1:0]    j_q, j_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [RIJ_W-1:0] rij_q, rij_d;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    rij_d   = rij_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d     = '0;
          state_d = S_NORM_REQ;
        end
      end
      S_NORM_REQ: state_d = S_NORM_WAIT;
      S_NORM_WAIT: begin
        if (i_norm_done) begin
          if (k_q == LAST_COL) begin
            state_d = S_DONE;
          end else begin
            j_d     = k_q + 1'b1;
            state_d = S_IP_REQ;
          end
        end
      end
      S_IP_REQ: state_d = S_IP_WAIT;
      S_IP_WAIT: begin
        if (i_ip_valid) begin
          rij_d   = i_ip_rij;
          state_d = S_PROJ;
        end
      end
      S_PROJ: begin
        if (PROJ_LAT == 1) begin
          state_d = S_WB;
        end else begin
          cnt_d   = PROJ_CNT_INIT;
          state_d = S_PROJ_WAIT;
        end
      end
      S_PROJ_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WB: begin
        // Last target of this pivot done: move on to normalizing the next pivot.
        if (j_q == LAST_COL) begin
          k_d     = k_q + 1'b1;
          state_d = S_NORM_REQ;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_IP_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort drops straight to IDLE and keeps indices and the captured R_kj.
    if (i_abort) begin
      state_d = S_IDLE;
      k_d     = k_q;
      j_d     = j_q;
      cnt_d   = cnt_q;
      rij_d   = rij_q;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (i_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      rij_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      rij_q   <= rij_d;
    end
  end

  // Every output is a register or a decode of the state register.
  assign o_norm_start = (state_q == S_NORM_REQ);
  assign o_ip_start   = (state_q == S_IP_REQ);
  assign o_proj_fire  = (state_q == S_PROJ);
  assign o_wb_en      = (state_q == S_WB);
  assign o_done       = (state_q == S_DONE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_k          = k_q;
  assign o_j          = j_q;
  assign o_rij        = rij_q;

endmodule

// File: tb/tb_qr_proj_ctrl.sv
// Self-checking bench for qr_proj_ctrl: two instances (PROJ_LAT 1 and 3) driven
// by delay-programmable responders and checked against a pair-order model.
module tb_qr_proj_ctrl;
  localparam int N_COL  = 4;
  localparam int RIJ_W  = 40;
  localparam int CW     = 2;
  localparam int N_PAIR = N_COL * (N_COL - 1) / 2;
  localparam int PLAT0  = 1;
  localparam int PLAT1  = 3;
  localparam int BUDGET = 300;
  localparam logic [RIJ_W-1:0] BASE = 40'h00010_00002;

  typedef struct {
    int d;
    int ndly;
    int idly;
    bit stray;
    int exp_done;
    int exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start, abort, norm_done, ip_valid;
  logic [1:0][RIJ_W-1:0] ip_rij;
  logic [1:0] norm_start, ip_start, proj_fire, wb_en, busy, done;
  logic [1:0][CW-1:0] k, j;
  logic [1:0][RIJ_W-1:0] rij;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pk[N_PAIR];
  int pj[N_PAIR];

  int norm_dly[2], ip_dly[2];
  bit rnd[2], stray[2];
  int ncnt[2], icnt[2];
  logic [RIJ_W-1:0] pend_rij[2];
  int exp_len[2];

  int t0[2], busy_cnt[2], done_cnt[2], done_cyc[2], last_done[2];
  int norm_cnt[2], ip_cnt[2], fire_cnt[2], wb_cnt[2], fire_cyc[2];

  qr_proj_ctrl #(.N_COL(N_COL), .RIJ_W(RIJ_W), .PROJ_LAT(PLAT0)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_abort(abort[0]),
    .o_norm_start(norm_start[0]), .i_norm_done(norm_done[0]),
    .o_ip_start(ip_start[0]), .i_ip_valid(ip_valid[0]), .i_ip_rij(ip_rij[0]),
    .o_k(k[0]), .o_j(j[0]), .o_rij(rij[0]), .o_proj_fire(proj_fire[0]),
    .o_wb_en(wb_en[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  qr_proj_ctrl #(.N_COL(N_COL), .RIJ_W(RIJ_W), .PROJ_LAT(PLAT1)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_abort(abort[1]),
    .o_norm_start(norm_start[1]), .i_norm_done(norm_done[1]),
    .o_ip_start(ip_start[1]), .i_ip_valid(ip_valid[1]), .i_ip_rij(ip_rij[1]),
    .o_k(k[1]), .o_j(j[1]), .o_rij(rij[1]), .o_proj_fire(proj_fire[1]),
    .o_wb_en(wb_en[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int plat_of(input int d);
    return (d == 0) ? PLAT0 : PLAT1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr(input int d);
    ncnt[d] = 0; icnt[d] = 0; exp_len[d] = 0;
    busy_cnt[d] = 0; done_cnt[d] = 0; done_cyc[d] = -1; last_done[d] = -1;
    norm_cnt[d] = 0; ip_cnt[d] = 0; fire_cnt[d] = 0; wb_cnt[d] = 0; fire_cyc[d] = 0;
  endtask

  task automatic go(input int d);
    clr(d);
    start[d] = 1'b1;
    t0[d] = cyc;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int n_done);
    for (int n = 0; n < BUDGET && done_cnt[d] < n_done; n++) tick();
    if (done_cnt[d] < n_done) check("done_timeout", 64'(done_cnt[d]), 64'(n_done));
    repeat (3) tick();
  endtask

  task automatic check_run(input int d, input int exp_done, input int exp_busy);
    check("done_cycle", 64'(done_cyc[d]), 64'(exp_done));
    check("busy_cycles", 64'(busy_cnt[d]), 64'(exp_busy));
    check("norm_count", 64'(norm_cnt[d]), 64'(N_COL));
    check("ip_count", 64'(ip_cnt[d]), 64'(N_PAIR));
    check("wb_count", 64'(wb_cnt[d]), 64'(N_PAIR));
    check("done_count", 64'(done_cnt[d]), 64'(1));
  endtask

  // Responders plus monitor, both acting on the falling edge.
  initial begin
    int dn, di, idx;
    logic [63:0] rv;
    norm_done = '0;
    ip_valid  = '0;
    ip_rij    = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        norm_done[d] = 1'b0;
        ip_valid[d]  = 1'b0;
        if (ncnt[d] > 0) begin
          ncnt[d]--;
          if (ncnt[d] == 0) norm_done[d] = 1'b1;
          else if (stray[d]) begin
            ip_valid[d] = 1'b1;
            ip_rij[d]   = 40'hBAD_0BAD_00;
          end
        end
        if (icnt[d] > 0) begin
          icnt[d]--;
          if (icnt[d] == 0) begin
            ip_valid[d] = 1'b1;
            ip_rij[d]   = pend_rij[d];
          end
        end
        if (norm_start[d] === 1'b1) begin
          dn = rnd[d] ? int'($urandom_range(1, 4)) : norm_dly[d];
          ncnt[d] = dn;
          exp_len[d] += 1 + dn;
        end
        if (ip_start[d] === 1'b1) begin
          di = rnd[d] ? int'($urandom_range(1, 4)) : ip_dly[d];
          rv = {$urandom, $urandom};
          pend_rij[d] = rnd[d] ? rv[RIJ_W-1:0] : BASE + RIJ_W'(ip_cnt[d]);
          icnt[d] = di;
          exp_len[d] += 2 + di + plat_of(d);
        end

        if (busy[d] === 1'b1) busy_cnt[d]++;
        if (done[d] === 1'b1) begin
          done_cnt[d]++;
          last_done[d] = cyc - t0[d];
          if (done_cyc[d] < 0) done_cyc[d] = cyc - t0[d];
        end
        if (norm_start[d] === 1'b1) begin
          check("norm_k", 64'(k[d]), 64'(norm_cnt[d] % N_COL));
          norm_cnt[d]++;
        end
        if (ip_start[d] === 1'b1) begin
          idx = ip_cnt[d] % N_PAIR;
          check("ip_k", 64'(k[d]), 64'(pk[idx]));
          check("ip_j", 64'(j[d]), 64'(pj[idx]));
          check("ip_after_norm", 64'(norm_cnt[d] % N_COL), 64'(pk[idx] + 1));
          ip_cnt[d]++;
        end
        if (proj_fire[d] === 1'b1) begin
          check("proj_rij", 64'(rij[d]), 64'(pend_rij[d]));
          fire_cyc[d] = cyc;
          fire_cnt[d]++;
        end
        if (wb_en[d] === 1'b1) begin
          idx = wb_cnt[d] % N_PAIR;
          check("wb_k", 64'(k[d]), 64'(pk[idx]));
          check("wb_j", 64'(j[d]), 64'(pj[idx]));
          check("wb_rij", 64'(rij[d]), 64'(pend_rij[d]));
          check("wb_latency", 64'(cyc - fire_cyc[d]), 64'(plat_of(d)));
          wb_cnt[d]++;
        end
      end
    end
  end

  initial begin
    vec_t tbl[5];
    int n, d;

    tbl[0] = '{0, 1, 1, 1'b0, 33, 33};
    tbl[1] = '{0, 3, 5, 1'b1, 65, 65};
    tbl[2] = '{1, 1, 1, 1'b0, 45, 45};
    tbl[3] = '{1, 3, 5, 1'b1, 77, 77};
    tbl[4] = '{0, 2, 1, 1'b0, 37, 37};

    // Reference pair order: every later column against each pivot.
    n = 0;
    for (int a = 0; a < N_COL; a++)
      for (int b = a + 1; b < N_COL; b++) begin
        pk[n] = a;
        pj[n] = b;
        n++;
      end

    rst = 1'b1; start = '0; abort = '0;
    for (int i = 0; i < 2; i++) begin
      clr(i); norm_dly[i] = 1; ip_dly[i] = 1; rnd[i] = 1'b0; stray[i] = 1'b0;
      pend_rij[i] = '0;
    end
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 64'(busy[i]), 64'(0));
      check("rst_strobes", 64'({norm_start[i], ip_start[i], proj_fire[i], wb_en[i], done[i]}), 64'(0));
      check("rst_kj", 64'({k[i], j[i]}), 64'(0));
      check("rst_rij", 64'(rij[i]), 64'(0));
    end
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      d = tbl[v].d;
      norm_dly[d] = tbl[v].ndly;
      ip_dly[d]   = tbl[v].idly;
      stray[d]    = tbl[v].stray;
      go(d);
      wait_done(d, 1);
      check_run(d, tbl[v].exp_done, tbl[v].exp_busy);
      stray[d] = 1'b0;
    end

    // Random responder delays and data; length predicted by summing phase costs.
    for (int r = 0; r < 6; r++) begin
      d = r % 2;
      rnd[d]   = 1'b1;
      stray[d] = 1'($urandom_range(0, 1));
      go(d);
      wait_done(d, 1);
      check_run(d, exp_len[d] + 1, exp_len[d] + 1);
      rnd[d] = 1'b0;
      stray[d] = 1'b0;
    end

    // i_start held high through the run, then pulsed while busy.
    norm_dly[0] = 1; ip_dly[0] = 1;
    clr(0);
    start[0] = 1'b1;
    t0[0] = cyc;
    for (int i = 0; i < BUDGET && done_cnt[0] == 0; i++) tick();
    check("hold_done_cycle", 64'(done_cyc[0]), 64'(33));
    tick();
    check("hold_idle_busy", 64'(busy[0]), 64'(0));
    tick();
    check("hold_restart_busy", 64'(busy[0]), 64'(1));
    check("hold_restart_norm", 64'(norm_start[0]), 64'(1));
    start[0] = 1'b0;
    repeat (10) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, 2);
    check("hold_second_done", 64'(last_done[0]), 64'(67));
    check("hold_done_count", 64'(done_cnt[0]), 64'(2));
    check("hold_wb_count", 64'(wb_cnt[0]), 64'(2 * N_PAIR));

    // Abort in IP_WAIT of pair (1,2), then rerun from k=0.
    norm_dly[0] = 1; ip_dly[0] = 5;
    go(0);
    for (int i = 0; i < BUDGET && ip_cnt[0] < 4; i++) tick();
    check("abort_reach_pair", 64'(ip_cnt[0]), 64'(4));
    tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_busy", 64'(busy[0]), 64'(0));
    check("abort_strobes", 64'({norm_start[0], ip_start[0], proj_fire[0], wb_en[0], done[0]}), 64'(0));
    check("abort_rij", 64'(rij[0]), 64'(BASE + 40'd2));
    repeat (8) tick();
    check("abort_no_done", 64'(done_cnt[0]), 64'(0));
    check("abort_wb_count", 64'(wb_cnt[0]), 64'(3));
    check("abort_rij_hold", 64'(rij[0]), 64'(BASE + 40'd2));
    ip_dly[0] = 1;
    go(0);
    wait_done(0, 1);
    check_run(0, 33, 33);

    // Reset in PROJ: everything clears, no write-back follows.
    go(0);
    for (int i = 0; i < BUDGET && fire_cnt[0] < 1; i++) tick();
    check("rst_reach_proj", 64'(fire_cnt[0]), 64'(1));
    rst = 1'b1;
    tick();
    check("rst_proj_outputs",
          64'({busy[0], norm_start[0], ip_start[0], proj_fire[0], wb_en[0], done[0], k[0], j[0], rij[0]}),
          64'(0));
    rst = 1'b0;
    repeat (5) tick();
    check("rst_no_wb", 64'(wb_cnt[0]), 64'(0));
    check("rst_stays_idle", 64'(busy[0]), 64'(0));

    // Reset together with start: stays idle.
    rst = 1'b1;
    start[0] = 1'b1;
    tick();
    check("rst_start_busy", 64'(busy[0]), 64'(0));
    rst = 1'b0;
    start[0] = 1'b0;
    tick();
    check("rst_start_idle", 64'(busy[0]), 64'(0));
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
